// File: rtl/ex_operand_stage.sv
// ex_operand_stage: single-entry pipeline register between decode and the ALU.
// It resolves operand A/B at capture time from the register file, the
// MEM-stage bypass or the WB-stage bypass, and selects the immediate for B
// when requested.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   in_valid / in_ready    decode handshake (in_ready is combinational)
//   in_cmd                 ALU operation, passed through untouched
//   in_rs1/2_idx/_val      source indices and register-file read data
//   in_imm, in_use_imm     sign-extended immediate and B-operand select
//   in_rd, in_rd_we        destination index and write enable
//   fwd_mem_*, fwd_wb_*    bypass sources (MEM has priority over WB)
//   flush                  drop the held and the incoming instruction
//   out_valid / out_ready  ALU handshake
//   out_cmd/a/b/rd/rd_we   registered operands and destination

package riscv_pkg;
  parameter int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_t;
endpackage

module ex_operand_stage #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  riscv_pkg::alu_cmd_t in_cmd,
  input  logic [4:0]          in_rs1_idx,
  input  logic [4:0]          in_rs2_idx,
  input  logic [XLEN-1:0]     in_rs1_val,
  input  logic [XLEN-1:0]     in_rs2_val,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                in_use_imm,
  input  logic [4:0]          in_rd,
  input  logic                in_rd_we,
  input  logic                fwd_mem_we,
  input  logic [4:0]          fwd_mem_rd,
  input  logic [XLEN-1:0]     fwd_mem_data,
  input  logic                fwd_wb_we,
  input  logic [4:0]          fwd_wb_rd,
  input  logic [XLEN-1:0]     fwd_wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output riscv_pkg::alu_cmd_t out_cmd,
  output logic [XLEN-1:0]     out_a,
  output logic [XLEN-1:0]     out_b,
  output logic [4:0]          out_rd,
  output logic                out_rd_we
);

  logic                valid_q, valid_d;
  riscv_pkg::alu_cmd_t cmd_q, cmd_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [4:0]          rd_q, rd_d;
  logic                rd_we_q, rd_we_d;

  logic                capture;
  logic [XLEN-1:0]     rs1_res;
  logic [XLEN-1:0]     rs2_res;

  // Stage is free when empty or when the held entry drains on this edge.
  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Bypass resolution; x0 is never forwarded, MEM beats WB.
  always_comb begin
    rs1_res = in_rs1_val;
    if (in_rs1_idx != '0) begin
      if (fwd_mem_we && (fwd_mem_rd == in_rs1_idx)) begin
        rs1_res = fwd_mem_data;
      end else if (fwd_wb_we && (fwd_wb_rd == in_rs1_idx)) begin
        rs1_res = fwd_wb_data;
      end
    end

    rs2_res = in_rs2_val;
    if (in_rs2_idx != '0) begin
      if (fwd_mem_we && (fwd_mem_rd == in_rs2_idx)) begin
        rs2_res = fwd_mem_data;
      end else if (fwd_wb_we && (fwd_wb_rd == in_rs2_idx)) begin
        rs2_res = fwd_wb_data;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;

    // Flush wins over everything; otherwise capture refills, and a drain
    // without refill empties the register.
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    // Data only changes on capture; flush leaves stale data behind.
    if (capture) begin
      cmd_d   = in_cmd;
      a_d     = rs1_res;
      b_d     = in_use_imm ? in_imm : rs2_res;
      rd_d    = in_rd;
      rd_we_d = in_rd_we && (in_rd != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      cmd_q   <= riscv_pkg::ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
    end
  end

  assign out_valid = valid_q;
  assign out_cmd   = cmd_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;

endmodule
